dsp_w_channel: RTL and testbench

DSP_W_CHANNEL -- requirements
Module: dsp_W_channel

---
 rtl/dsp_w_channel_if.sv | 30 +++
 rtl/dsp_w_channel.sv | 84 ++++++++
 tb/tb_dsp_w_channel.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_w_channel_if.sv
// Bus bundle for the W-channel dispatcher: master-side beat handshake, Ax dispatcher
// hints, and the per-slave outputs toward slave arbitration.
interface dsp_w_channel_if #(
  parameter int SLV_AMT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_ID_W   = $clog2(SLV_AMT)
) ();
  logic [DATA_WIDTH-1:0]         m_WDATA_i;
  logic                          m_WLAST_i;
  logic                          m_WVALID_i;
  logic                          m_WREADY_o;
  logic [SLV_ID_W-1:0]           dsp_slv_id_i;
  logic                          dsp_disable_i;
  logic [DATA_WIDTH*SLV_AMT-1:0] sa_WDATA_o;
  logic [SLV_AMT-1:0]            sa_WLAST_o;
  logic [SLV_AMT-1:0]            sa_WVALID_o;
  logic [SLV_AMT-1:0]            sa_WREADY_i;

  // Environment side: drives master beats, dispatcher hints and slave readies.
  modport master (
    output m_WDATA_i, m_WLAST_i, m_WVALID_i, dsp_slv_id_i, dsp_disable_i, sa_WREADY_i,
    input  m_WREADY_o, sa_WDATA_o, sa_WLAST_o, sa_WVALID_o
  );

  // Dispatcher side.
  modport slave (
    input  m_WDATA_i, m_WLAST_i, m_WVALID_i, dsp_slv_id_i, dsp_disable_i, sa_WREADY_i,
    output m_WREADY_o, sa_WDATA_o, sa_WLAST_o, sa_WVALID_o
  );
endinterface

// File: rtl/dsp_w_channel.sv
// W-channel dispatcher: 2-entry skid buffer that tags each beat with its target slave
// at acceptance time and steers it to that slave's one-hot valid.
module dsp_w_channel #(
  parameter int SLV_AMT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_ID_W   = $clog2(SLV_AMT)
) (
  input  logic                  ACLK_i,
  input  logic                  ARESET_i,
  dsp_w_channel_if.slave        bus,
  output logic [1:0]            dsp_W_occ_o,
  output logic                  dsp_W_err_o
);

  typedef struct packed {
    logic [SLV_ID_W-1:0]   slvId;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  valid;
  } entry_t;

  entry_t mainQ, skidQ, mainD, skidD, beat;
  logic   errQ;
  logic   mHs, storeHs, outHs, idInRange;

  // Handshakes: a beat moves when valid and ready are both high on a rising edge.
  // Ready never looks at valid; valid, once high, holds with stable payload until taken.
  assign idInRange = ({1'b0, bus.dsp_slv_id_i} < (SLV_ID_W + 1)'(SLV_AMT));
  assign bus.m_WREADY_o = ~skidQ.valid & ~bus.dsp_disable_i & ~ARESET_i;
  assign mHs     = bus.m_WVALID_i & bus.m_WREADY_o;
  assign storeHs = mHs & idInRange;
  assign outHs   = |(bus.sa_WVALID_o & bus.sa_WREADY_i);

  always_comb begin
    beat.slvId = bus.dsp_slv_id_i;
    beat.data  = bus.m_WDATA_i;
    beat.last  = bus.m_WLAST_i;
    beat.valid = 1'b1;
  end

  always_comb begin
    bus.sa_WVALID_o = '0;
    for (int k = 0; k < SLV_AMT; k++) begin
      bus.sa_WVALID_o[k] = mainQ.valid & ~ARESET_i & (mainQ.slvId == SLV_ID_W'(k));
    end
  end

  assign bus.sa_WDATA_o = {SLV_AMT{mainQ.data}};
  assign bus.sa_WLAST_o = {SLV_AMT{mainQ.last}};
  assign dsp_W_occ_o    = ARESET_i ? 2'd0 : ({1'b0, mainQ.valid} + {1'b0, skidQ.valid});
  assign dsp_W_err_o    = errQ;

  // Out-of-range beats complete the handshake but never enter the buffer.
  always_comb begin
    mainD = mainQ;
    skidD = skidQ;
    if (!mainQ.valid) begin
      if (storeHs) mainD = beat;
    end else if (!skidQ.valid) begin
      if (outHs) begin
        if (storeHs) mainD = beat;
        else         mainD.valid = 1'b0;
      end else if (storeHs) begin
        skidD = beat;
      end
    end else if (outHs) begin
      mainD       = skidQ;
      skidD.valid = 1'b0;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      mainQ.valid <= 1'b0;
      skidQ.valid <= 1'b0;
      errQ        <= 1'b0;
    end else begin
      mainQ <= mainD;
      skidQ <= skidD;
      if (mHs && !idInRange) errQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_w_channel.sv
// Directed bench for dsp_w_channel: a 2-slave instance for the main paths and a
// 3-slave instance for the out-of-range slave-ID case.
module tb_dsp_w_channel;

  logic       ACLK_i;
  logic       ARESET_i;
  logic [1:0] occ2, occ3;
  logic       err2, err3;
  int         errCnt = 0;
  int         chkCnt = 0;

  dsp_w_channel_if #(.SLV_AMT(2), .DATA_WIDTH(32)) bus2 ();
  dsp_w_channel_if #(.SLV_AMT(3), .DATA_WIDTH(32)) bus3 ();

  dsp_w_channel #(.SLV_AMT(2), .DATA_WIDTH(32)) dut2 (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i), .bus(bus2),
    .dsp_W_occ_o(occ2), .dsp_W_err_o(err2)
  );

  dsp_w_channel #(.SLV_AMT(3), .DATA_WIDTH(32)) dut3 (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i), .bus(bus3),
    .dsp_W_occ_o(occ3), .dsp_W_err_o(err3)
  );

  // Clock and reset
  initial begin
    ACLK_i = 1'b0;
    forever #5 ACLK_i = ~ACLK_i;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [31:0] d, input logic l, input logic id);
    bus2.m_WVALID_i   = v;
    bus2.m_WDATA_i    = d;
    bus2.m_WLAST_i    = l;
    bus2.dsp_slv_id_i = id;
  endtask

  initial begin
    ARESET_i = 1'b1;
    drive2(1'b0, 32'h0, 1'b0, 1'b0);
    bus2.dsp_disable_i = 1'b0;
    bus2.sa_WREADY_i   = 2'b00;
    bus3.m_WVALID_i    = 1'b0;
    bus3.m_WDATA_i     = 32'h0;
    bus3.m_WLAST_i     = 1'b0;
    bus3.dsp_slv_id_i  = 2'd0;
    bus3.dsp_disable_i = 1'b0;
    bus3.sa_WREADY_i   = 3'b000;
    tick();
    tick();

    // Reset state
    check("rst_ready", bus2.m_WREADY_o, 1'b0);
    check("rst_occ", occ2, 2'd0);
    check("rst_valid", bus2.sa_WVALID_o, 2'b00);
    check("rst_err", err2, 1'b0);
    ARESET_i = 1'b0;
    #1;
    check("idle_ready", bus2.m_WREADY_o, 1'b1);

    // Single beat to slave 1, one-cycle latency
    bus2.sa_WREADY_i = 2'b10;
    drive2(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1);
    tick();
    drive2(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    check("t1_valid", bus2.sa_WVALID_o, 2'b10);
    check("t1_data", bus2.sa_WDATA_o[63:32], 32'hA5A5_A5A5);
    check("t1_last", bus2.sa_WLAST_o, 2'b11);
    check("t1_occ", occ2, 2'd1);
    tick();
    check("t1_occ_after", occ2, 2'd0);
    check("t1_valid_after", bus2.sa_WVALID_o, 2'b00);

    // Backpressure: two beats accepted, third refused, then in-order drain
    bus2.sa_WREADY_i = 2'b00;
    drive2(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    drive2(1'b1, 32'h22, 1'b0, 1'b0);
    #1;
    check("t2_ready_b2", bus2.m_WREADY_o, 1'b1);
    tick();
    drive2(1'b1, 32'h33, 1'b1, 1'b0);
    #1;
    check("t2_ready_b3", bus2.m_WREADY_o, 1'b0);
    check("t2_occ_full", occ2, 2'd2);
    tick();
    check("t2_occ_hold", occ2, 2'd2);
    check("t2_data_hold", bus2.sa_WDATA_o[31:0], 32'h11);
    drive2(1'b0, 32'h0, 1'b0, 1'b0);
    bus2.sa_WREADY_i = 2'b01;
    #1;
    check("t2_drain1_valid", bus2.sa_WVALID_o, 2'b01);
    check("t2_drain1_data", bus2.sa_WDATA_o[31:0], 32'h11);
    tick();
    check("t2_drain2_data", bus2.sa_WDATA_o[31:0], 32'h22);
    check("t2_drain2_occ", occ2, 2'd1);
    tick();
    check("t2_drain_done", occ2, 2'd0);

    // Slave ID switches while an earlier beat is still buffered
    bus2.sa_WREADY_i = 2'b00;
    drive2(1'b1, 32'hDEAD, 1'b0, 1'b0);
    tick();
    drive2(1'b1, 32'hBEEF, 1'b1, 1'b1);
    tick();
    drive2(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    check("t3_first_valid", bus2.sa_WVALID_o, 2'b01);
    check("t3_first_data", bus2.sa_WDATA_o[31:0], 32'hDEAD);
    bus2.sa_WREADY_i = 2'b01;
    tick();
    check("t3_second_valid", bus2.sa_WVALID_o, 2'b10);
    check("t3_second_data", bus2.sa_WDATA_o[63:32], 32'hBEEF);
    check("t3_second_last", bus2.sa_WLAST_o, 2'b11);
    bus2.sa_WREADY_i = 2'b10;
    tick();
    check("t3_empty", occ2, 2'd0);

    // Disable blocks new beats while buffered beats drain
    bus2.sa_WREADY_i = 2'b00;
    drive2(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    bus2.dsp_disable_i = 1'b1;
    drive2(1'b1, 32'h88, 1'b0, 1'b0);
    #1;
    check("t4_ready_dis", bus2.m_WREADY_o, 1'b0);
    tick();
    check("t4_no_capture", occ2, 2'd1);
    check("t4_data", bus2.sa_WDATA_o[31:0], 32'h77);
    bus2.sa_WREADY_i = 2'b01;
    tick();
    check("t4_drained", occ2, 2'd0);
    check("t4_valid_off", bus2.sa_WVALID_o, 2'b00);
    bus2.dsp_disable_i = 1'b0;
    drive2(1'b0, 32'h0, 1'b0, 1'b0);

    // Out-of-range slave ID on the 3-slave instance
    bus3.dsp_slv_id_i = 2'd3;
    bus3.m_WDATA_i    = 32'h55;
    bus3.m_WVALID_i   = 1'b1;
    #1;
    check("t5_ready", bus3.m_WREADY_o, 1'b1);
    tick();
    bus3.m_WVALID_i = 1'b0;
    #1;
    check("t5_valid", bus3.sa_WVALID_o, 3'b000);
    check("t5_occ", occ3, 2'd0);
    check("t5_err", err3, 1'b1);
    bus3.dsp_slv_id_i = 2'd2;
    bus3.m_WDATA_i    = 32'h66;
    bus3.m_WVALID_i   = 1'b1;
    tick();
    bus3.m_WVALID_i = 1'b0;
    #1;
    check("t5_valid_id2", bus3.sa_WVALID_o, 3'b100);
    check("t5_data_id2", bus3.sa_WDATA_o[95:64], 32'h66);
    check("t5_err_sticky", err3, 1'b1);

    // Reset with a full buffer
    bus2.sa_WREADY_i = 2'b00;
    drive2(1'b1, 32'hC1, 1'b0, 1'b1);
    tick();
    drive2(1'b1, 32'hC2, 1'b1, 1'b1);
    tick();
    drive2(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t6_full", occ2, 2'd2);
    ARESET_i = 1'b1;
    tick();
    check("t6_occ", occ2, 2'd0);
    check("t6_valid", bus2.sa_WVALID_o, 2'b00);
    check("t6_ready", bus2.m_WREADY_o, 1'b0);
    check("t6_err_cleared", err3, 1'b0);
    tick();
    ARESET_i = 1'b0;
    bus2.sa_WREADY_i = 2'b11;
    #1;
    check("t6_post_valid", bus2.sa_WVALID_o, 2'b00);
    check("t6_post_occ", occ2, 2'd0);
    check("t6_post_ready", bus2.m_WREADY_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
